// File: rtl/oci_debug_mem_access.sv
// Debug memory-access engine: turns JTAG debug strobes into single-word
// Avalon-MM reads/writes with address auto-increment and a stall timeout.
module oci_debug_mem_access #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int TCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  logic [TCNT_W-1:0]   tcnt_reg;
  logic                any_strobe;

  assign any_strobe     = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // Address and write data come straight from registers, so the bus stays glitch-free.
  assign avm_address    = {addr_reg, 2'b00};
  assign avm_writedata  = wdata_reg;
  assign avm_byteenable = 4'hF;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      tcnt_reg      <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (take_action_ocimem_a) begin
            addr_reg <= jdo[ADDR_W-1:0];
            if (jdo[35]) begin
              state_reg     <= READ;
              avm_read      <= 1'b1;
              monitor_ready <= 1'b0;
              monitor_error <= 1'b0;
              tcnt_reg      <= '0;
            end
          end else if (take_action_ocimem_b) begin
            wdata_reg     <= jdo[31:0];
            state_reg     <= WRITE;
            avm_write     <= 1'b1;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            tcnt_reg      <= '0;
          end else if (take_no_action_ocimem_a) begin
            state_reg     <= READ;
            avm_read      <= 1'b1;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            tcnt_reg      <= '0;
          end
        end

        READ, WRITE: begin
          if (!avm_waitrequest) begin
            if (state_reg == READ) MonDReg <= avm_readdata;
            addr_reg      <= addr_reg + 1'b1;
            monitor_ready <= 1'b1;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            state_reg     <= IDLE;
          end else if (tcnt_reg == TCNT_MAX) begin
            // Abort: address and read data are left untouched.
            monitor_ready <= 1'b1;
            monitor_error <= 1'b1;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
          // Commands arriving mid-access are dropped but flagged.
          if (any_strobe) monitor_error <= 1'b1;
        end

        default: begin
          state_reg <= IDLE;
          avm_read  <= 1'b0;
          avm_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oci_debug_mem_access.sv
// Scoreboard bench for oci_debug_mem_access: stimulus pushes expected bus
// transfers and results; a negedge monitor pops and compares them.
module tb_oci_debug_mem_access;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [37:0]       jdo = '0;
  logic              take_action_ocimem_a = 1'b0;
  logic              take_action_ocimem_b = 1'b0;
  logic              take_no_action_ocimem_a = 1'b0;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic [ADDR_W+1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_readdata = '0;
  logic              avm_waitrequest = 1'b0;

  oci_debug_mem_access #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [17:0] a;
    logic [31:0] d;
  } bus_t;

  typedef struct {
    logic [31:0] mon;
    logic        err;
  } res_t;

  bus_t exp_bus[$];
  res_t exp_res[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  int   stall_left = 0;
  logic stuck = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Slave model: decides waitrequest for the coming cycle just after each edge.
  always begin
    @(posedge clk);
    #1;
    if (stuck) avm_waitrequest = 1'b1;
    else if ((avm_read || avm_write) && stall_left > 0) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end else avm_waitrequest = 1'b0;
  end

  // Monitor: completed bus handshakes and monitor_ready rising edges.
  initial begin
    logic prev_ready;
    bus_t b;
    res_t r;
    prev_ready = 1'b1;
    forever begin
      @(negedge clk);
      if ((avm_read || avm_write) && !avm_waitrequest && !reset) begin
        if (exp_bus.size() == 0) begin
          check("unexpected_bus_txn", {avm_write, avm_address}, 64'h0);
        end else begin
          b = exp_bus.pop_front();
          check("bus_is_write", {63'h0, avm_write}, {63'h0, b.wr});
          check("bus_address", {46'h0, avm_address}, {46'h0, b.a});
          if (b.wr) check("bus_writedata", {32'h0, avm_writedata}, {32'h0, b.d});
        end
      end
      if (monitor_ready && !prev_ready) begin
        if (exp_res.size() == 0) begin
          check("unexpected_ready", {32'h0, MonDReg}, 64'h0);
        end else begin
          r = exp_res.pop_front();
          $display("[TB] result MonDReg=%08h error=%0d", MonDReg, monitor_error);
          check("MonDReg", {32'h0, MonDReg}, {32'h0, r.mon});
          check("monitor_error", {63'h0, monitor_error}, {63'h0, r.err});
        end
      end
      prev_ready = monitor_ready;
    end
  end

  // kind bitmask: 1 = take_action_a, 2 = take_action_b, 4 = take_no_action_a
  task automatic strobe(input int kind, input logic [37:0] d);
    @(negedge clk);
    jdo = d;
    take_action_ocimem_a    = kind[0];
    take_action_ocimem_b    = kind[1];
    take_no_action_ocimem_a = kind[2];
    @(negedge clk);
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic count_req(output int n);
    n = 0;
    while ((avm_read || avm_write) && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!monitor_ready && k < 100) begin
      k++;
      @(negedge clk);
    end
    check(name, {63'h0, monitor_ready}, 64'h1);
  endtask

  task automatic push_bus(input logic wr, input logic [17:0] a, input logic [31:0] d);
    bus_t b;
    b.wr = wr; b.a = a; b.d = d;
    exp_bus.push_back(b);
  endtask

  task automatic push_res(input logic [31:0] m, input logic e);
    res_t r;
    r.mon = m; r.err = e;
    exp_res.push_back(r);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {63'h0, monitor_ready}, 64'h1);
    check("rst_error", {63'h0, monitor_error}, 64'h0);
    check("rst_rw", {62'h0, avm_read, avm_write}, 64'h0);
    check("rst_address", {46'h0, avm_address}, 64'h0);
    check("rst_writedata", {32'h0, avm_writedata}, 64'h0);
    check("rst_mondreg", {32'h0, MonDReg}, 64'h0);
    check("byteenable", {60'h0, avm_byteenable}, 64'hF);

    // Address load only
    strobe(1, 38'h00_0000_0010);
    @(negedge clk);
    check("aload_no_bus", {62'h0, avm_read, avm_write}, 64'h0);
    check("aload_ready", {63'h0, monitor_ready}, 64'h1);
    check("aload_address", {46'h0, avm_address}, 64'h40);

    // Write DEADBEEF at 0x40, no stall
    push_bus(1'b1, 18'h00040, 32'hDEADBEEF);
    push_res(32'h0, 1'b0);
    strobe(2, 38'h00_DEAD_BEEF);
    count_req(n);
    $display("[TB] write 0x40 cycles=%0d", n);
    check("write_cycles", 64'(n), 64'd1);

    // Streaming read at 0x44
    avm_readdata = 32'hCAFEF00D;
    push_bus(1'b0, 18'h00044, 32'h0);
    push_res(32'hCAFEF00D, 1'b0);
    strobe(4, 38'h0);
    count_req(n);
    check("read44_cycles", 64'(n), 64'd1);

    // Read at 0x80 with 3 stall cycles
    avm_readdata = 32'h12345678;
    stall_left = 3;
    push_bus(1'b0, 18'h00080, 32'h0);
    push_res(32'h12345678, 1'b0);
    strobe(1, 38'h08_0000_0020);
    count_req(n);
    $display("[TB] stalled read cycles=%0d", n);
    check("stall_read_cycles", 64'(n), 64'd4);

    // Timeout on read at 0x84
    stuck = 1'b1;
    avm_readdata = 32'hFFFF0000;
    push_res(32'h12345678, 1'b1);
    strobe(4, 38'h0);
    count_req(n);
    $display("[TB] timeout read cycles=%0d", n);
    check("timeout_cycles", 64'(n), 64'(TIMEOUT + 1));
    check("timeout_addr_kept", {46'h0, avm_address}, 64'h84);
    stuck = 1'b0;
    @(negedge clk);

    // Wrap: read at 0xFFFF then next at 0
    avm_readdata = 32'hA5A50001;
    push_bus(1'b0, 18'h3FFFC, 32'h0);
    push_res(32'hA5A50001, 1'b0);
    strobe(1, 38'h08_0000_FFFF);
    wait_ready("wrap_read_done");
    check("wrap_address", {46'h0, avm_address}, 64'h0);
    avm_readdata = 32'h0000BEEF;
    push_bus(1'b0, 18'h00000, 32'h0);
    push_res(32'h0000BEEF, 1'b0);
    strobe(4, 38'h0);
    wait_ready("read0_done");

    // Strobe injected during a stalled read at 0x4
    avm_readdata = 32'h77778888;
    stall_left = 5;
    push_bus(1'b0, 18'h00004, 32'h0);
    push_res(32'h77778888, 1'b1);
    strobe(4, 38'h0);
    strobe(2, 38'h00_1111_1111);
    wait_ready("inject_read_done");
    repeat (3) @(negedge clk);
    check("inject_wdata_kept", {32'h0, avm_writedata}, 64'hDEADBEEF);
    check("inject_no_extra", {62'h0, avm_read, avm_write}, 64'h0);

    // Priority: address load beats write-data strobe
    strobe(3, 38'h00_0000_0030);
    repeat (2) @(negedge clk);
    check("prio_no_bus", {62'h0, avm_read, avm_write}, 64'h0);
    check("prio_address", {46'h0, avm_address}, 64'hC0);
    check("prio_wdata_kept", {32'h0, avm_writedata}, 64'hDEADBEEF);

    // Reset during a stalled write
    stall_left = 5;
    push_res(32'h0, 1'b0);
    strobe(2, 38'h00_55AA_55AA);
    @(negedge clk);
    check("pre_reset_write", {63'h0, avm_write}, 64'h1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_write_low", {63'h0, avm_write}, 64'h0);
    check("reset_ready", {63'h0, monitor_ready}, 64'h1);
    check("reset_address", {46'h0, avm_address}, 64'h0);
    reset = 1'b0;
    stall_left = 0;
    @(negedge clk);

    // Engine resumes at address 0
    avm_readdata = 32'h0BADCAFE;
    push_bus(1'b0, 18'h00000, 32'h0);
    push_res(32'h0BADCAFE, 1'b0);
    strobe(4, 38'h0);
    wait_ready("post_reset_read");
    repeat (2) @(negedge clk);

    check("bus_queue_drained", 64'(exp_bus.size()), 64'd0);
    check("res_queue_drained", 64'(exp_res.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
